// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for mem_ctrl: FSM state encoding, access-length codes and the IO base default.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ST,
    S_LD,
    S_IF,
    S_DONE
  } state_t;

  localparam logic [5:0]  LEN_B       = 6'd8;
  localparam logic [5:0]  LEN_H       = 6'd16;
  localparam logic [5:0]  LEN_W       = 6'd32;
  localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;

  // Unrecognised lengths fall back to a full word.
  function automatic logic [2:0] len_to_bytes(input logic [5:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      LEN_W:   return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial controller arbitrating LSB loads/stores and instruction fetches onto the 8-bit RAM/IO bus.
// Optional `MEM_IO_STALL_EN: hold IO-region write bytes while the UART buffer reports full.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEF,
  parameter int          ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              lsb_ld_req,
  input  logic              lsb_st_req,
  input  logic [5:0]        lsb_len,
  input  logic [31:0]       lsb_addr,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_done,
  output logic [31:0]       lsb_rdata,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_cnt;
  logic [2:0]          r_nbytes;
  logic [31:0]         r_buf;
  logic [ADDR_W-1:0]   r_mem_a;
  logic [7:0]          r_mem_dout;
  logic                r_mem_wr;
  logic                r_lsb_done;
  logic                r_if_done;
  logic [31:0]         r_lsb_rdata;
  logic [31:0]         r_if_inst;

  logic                w_acc_st;
  logic                w_acc_ld;
  logic                w_acc_if;
  logic                w_adv;
  logic                w_last;
  logic                w_stall;
  logic [1:0]          w_byte_idx;
  logic [31:0]         w_buf_ins;

`ifdef MEM_IO_STALL_EN
  assign w_stall = (r_state == S_ST) && (r_mem_a >= ADDR_W'(IO_BASE)) && io_buffer_full;
`else
  logic w_unused_io;
  assign w_unused_io = io_buffer_full;
  assign w_stall     = 1'b0;
`endif

  // Byte read during cycle k lands in slot k; it arrives while the counter already reads k+1.
  assign w_byte_idx = r_cnt[1:0] - 2'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_st    = 1'b0;
    w_acc_ld    = 1'b0;
    w_acc_if    = 1'b0;
    w_adv       = 1'b0;
    w_last      = 1'b0;
    w_buf_ins   = r_buf;
    w_buf_ins[{w_byte_idx, 3'b000} +: 8] = mem_din;
    case (r_state)
      S_IDLE: begin
        if (!clear) begin
          if (lsb_st_req) begin
            w_acc_st    = 1'b1;
            w_state_nxt = S_ST;
          end else if (lsb_ld_req) begin
            w_acc_ld    = 1'b1;
            w_state_nxt = S_LD;
          end else if (if_req) begin
            w_acc_if    = 1'b1;
            w_state_nxt = S_IF;
          end
        end
      end
      S_ST: begin
        if (!w_stall) begin
          w_adv = 1'b1;
          if (r_cnt == r_nbytes - 3'd1) begin
            w_last      = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_LD, S_IF: begin
        if (clear) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_adv = 1'b1;
          if (r_cnt == r_nbytes) begin
            w_last      = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_nbytes    <= '0;
      r_buf       <= '0;
      r_mem_a     <= '0;
      r_mem_dout  <= '0;
      r_mem_wr    <= 1'b0;
      r_lsb_done  <= 1'b0;
      r_if_done   <= 1'b0;
      r_lsb_rdata <= '0;
      r_if_inst   <= '0;
    end else if (rdy) begin
      r_state    <= w_state_nxt;
      r_lsb_done <= 1'b0;
      r_if_done  <= 1'b0;
      if (w_acc_st) begin
        r_mem_a    <= ADDR_W'(lsb_addr);
        r_mem_dout <= lsb_wdata[7:0];
        r_buf      <= lsb_wdata >> 8;
        r_mem_wr   <= 1'b1;
        r_cnt      <= '0;
        r_nbytes   <= len_to_bytes(lsb_len);
      end else if (w_acc_ld || w_acc_if) begin
        r_mem_a  <= w_acc_ld ? ADDR_W'(lsb_addr) : ADDR_W'(if_addr);
        r_buf    <= '0;
        r_mem_wr <= 1'b0;
        r_cnt    <= '0;
        r_nbytes <= w_acc_ld ? len_to_bytes(lsb_len) : 3'd4;
      end else if (w_adv && r_state == S_ST) begin
        if (w_last) begin
          r_mem_wr   <= 1'b0;
          r_lsb_done <= 1'b1;
        end else begin
          r_mem_a    <= r_mem_a + ADDR_W'(1);
          r_mem_dout <= r_buf[7:0];
          r_buf      <= r_buf >> 8;
          r_cnt      <= r_cnt + 3'd1;
        end
      end else if (w_adv) begin
        r_mem_a <= r_mem_a + ADDR_W'(1);
        r_cnt   <= r_cnt + 3'd1;
        if (r_cnt != 3'd0) r_buf <= w_buf_ins;
        if (w_last && r_state == S_LD) begin
          r_lsb_rdata <= w_buf_ins;
          r_lsb_done  <= 1'b1;
        end else if (w_last) begin
          r_if_inst <= w_buf_ins;
          r_if_done <= 1'b1;
        end
      end
    end
  end

  assign mem_a     = r_mem_a;
  assign mem_dout  = r_mem_dout;
  assign mem_wr    = r_mem_wr & rdy & ~w_stall;
  assign lsb_done  = r_lsb_done;
  assign lsb_rdata = r_lsb_rdata;
  assign if_done   = r_if_done;
  assign if_inst   = r_if_inst;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed scoreboard bench for mem_ctrl: stimulus pushes expected writes/completions, a negedge monitor checks them.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic        lsb_ld_req, lsb_st_req;
  logic [5:0]  lsb_len;
  logic [31:0] lsb_addr, lsb_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_inst;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .lsb_ld_req(lsb_ld_req), .lsb_st_req(lsb_st_req), .lsb_len(lsb_len),
    .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: one-cycle read latency, stalled together with the controller when rdy is low.
  logic [7:0] ram [logic [31:0]];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    if (rdy) mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
  end

  typedef struct { logic [31:0] a; logic [7:0] d; int cyc; } wr_t;
  typedef struct { bit chk; logic [31:0] d; int cyc; } rsp_t;
  wr_t  wq[$];
  rsp_t lq[$];
  rsp_t iq[$];
  wr_t  we;
  rsp_t re;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [7:0] d, input int c);
    wr_t e;
    e.a = a; e.d = d; e.cyc = c;
    wq.push_back(e);
  endtask

  task automatic push_lsb(input bit ck, input logic [31:0] d, input int c);
    rsp_t e;
    e.chk = ck; e.d = d; e.cyc = c;
    lq.push_back(e);
  endtask

  task automatic push_if(input logic [31:0] d, input int c);
    rsp_t e;
    e.chk = 1'b1; e.d = d; e.cyc = c;
    iq.push_back(e);
  endtask

  task automatic wait_lsb();
    int n = 0;
    do begin @(negedge clk); n++; end while (!lsb_done && n < 60);
    if (!lsb_done) begin
      checks++; errors++;
      $display("FAIL lsb_timeout got=no_done exp=done");
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_if();
    int n = 0;
    do begin @(negedge clk); n++; end while (!if_done && n < 60);
    if (!if_done) begin
      checks++; errors++;
      $display("FAIL if_timeout got=no_done exp=done");
    end
    @(posedge clk); #1;
  endtask

  task automatic step(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wr) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected got a=%h d=%h cyc=%0d exp=none", mem_a, mem_dout, cyc);
        end else begin
          we = wq.pop_front();
          if (mem_a !== we.a || mem_dout !== we.d || cyc != we.cyc) begin
            errors++;
            $display("FAIL wr_byte got a=%h d=%h cyc=%0d exp a=%h d=%h cyc=%0d",
                     mem_a, mem_dout, cyc, we.a, we.d, we.cyc);
          end
        end
      end
      if (lsb_done) begin
        checks++;
        if (lq.size() == 0) begin
          errors++;
          $display("FAIL lsb_done_unexpected got cyc=%0d exp=none", cyc);
        end else begin
          re = lq.pop_front();
          if (cyc != re.cyc || (re.chk && lsb_rdata !== re.d)) begin
            errors++;
            $display("FAIL lsb_rsp got d=%h cyc=%0d exp d=%h cyc=%0d", lsb_rdata, cyc, re.d, re.cyc);
          end
        end
      end
      if (if_done) begin
        checks++;
        if (iq.size() == 0) begin
          errors++;
          $display("FAIL if_done_unexpected got cyc=%0d exp=none", cyc);
        end else begin
          re = iq.pop_front();
          if (cyc != re.cyc || if_inst !== re.d) begin
            errors++;
            $display("FAIL if_rsp got d=%h cyc=%0d exp d=%h cyc=%0d", if_inst, cyc, re.d, re.cyc);
          end
        end
      end
    end
  end

  initial begin
    int c0;
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    lsb_ld_req = 1'b0; lsb_st_req = 1'b0; lsb_len = 6'd0; lsb_addr = '0; lsb_wdata = '0;
    if_req = 1'b0; if_addr = '0; io_buffer_full = 1'b0;
    ram[32'h200] = 8'h34; ram[32'h201] = 8'h12; ram[32'h202] = 8'hFF;
    ram[32'h0] = 8'h13; ram[32'h1] = 8'h05; ram[32'h2] = 8'h00; ram[32'h3] = 8'h00;
    ram[32'h40] = 8'h11; ram[32'h41] = 8'h22; ram[32'h42] = 8'h33; ram[32'h43] = 8'h44;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_lsb_done", {31'd0, lsb_done}, 32'd0);
    chk("rst_if_done", {31'd0, if_done}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_lsb_rdata", lsb_rdata, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // word store: four consecutive bytes, done one cycle after the last
    c0 = cyc;
    push_wr(32'h100, 8'hEF, c0 + 1); push_wr(32'h101, 8'hBE, c0 + 2);
    push_wr(32'h102, 8'hAD, c0 + 3); push_wr(32'h103, 8'hDE, c0 + 4);
    push_lsb(1'b0, 32'h0, c0 + 5);
    lsb_addr = 32'h100; lsb_len = 6'd32; lsb_wdata = 32'hDEADBEEF; lsb_st_req = 1'b1;
    wait_lsb(); lsb_st_req = 1'b0;

    // clear during a store must not abort it
    c0 = cyc;
    push_wr(32'h180, 8'h5A, c0 + 1); push_wr(32'h181, 8'hA5, c0 + 2);
    push_lsb(1'b0, 32'h0, c0 + 3);
    lsb_addr = 32'h180; lsb_len = 6'd16; lsb_wdata = 32'h1234A55A; lsb_st_req = 1'b1;
    fork
      begin wait_lsb(); lsb_st_req = 1'b0; end
      begin step(2); clear = 1'b1; step(1); clear = 1'b0; end
    join

    // halfword load, upper bytes zero even though RAM beyond holds 0xFF
    c0 = cyc;
    push_lsb(1'b1, 32'h0000_1234, c0 + 4);
    lsb_addr = 32'h200; lsb_len = 6'd16; lsb_ld_req = 1'b1;
    wait_lsb(); lsb_ld_req = 1'b0;

    // byte load of a previously stored byte
    c0 = cyc;
    push_lsb(1'b1, 32'h0000_00DE, c0 + 3);
    lsb_addr = 32'h103; lsb_len = 6'd8; lsb_ld_req = 1'b1;
    wait_lsb(); lsb_ld_req = 1'b0;

    // illegal length behaves as a word
    c0 = cyc;
    push_lsb(1'b1, 32'hDEADBEEF, c0 + 6);
    lsb_addr = 32'h100; lsb_len = 6'd0; lsb_ld_req = 1'b1;
    wait_lsb(); lsb_ld_req = 1'b0;

    // store and load together: store first, load sees the new byte
    c0 = cyc;
    push_wr(32'h1F0, 8'h77, c0 + 1);
    push_lsb(1'b0, 32'h0, c0 + 2);
    push_lsb(1'b1, 32'h0000_0077, c0 + 6);
    lsb_addr = 32'h1F0; lsb_len = 6'd8; lsb_wdata = 32'h0000_0077;
    lsb_st_req = 1'b1; lsb_ld_req = 1'b1;
    wait_lsb(); lsb_st_req = 1'b0;
    wait_lsb(); lsb_ld_req = 1'b0;

    // load wins over a simultaneous fetch
    c0 = cyc;
    push_lsb(1'b1, 32'h4433_2211, c0 + 6);
    push_if(32'h0000_0513, c0 + 13);
    lsb_addr = 32'h40; lsb_len = 6'd32; lsb_ld_req = 1'b1;
    if_addr = 32'h0; if_req = 1'b1;
    fork
      begin wait_lsb(); lsb_ld_req = 1'b0; end
      begin wait_if(); if_req = 1'b0; end
    join

    // flush a fetch after two bytes; a load right after proves the controller is idle
    c0 = cyc;
    if_addr = 32'h40; if_req = 1'b1;
    step(4); clear = 1'b1; if_req = 1'b0;
    step(1); clear = 1'b0;
    c0 = cyc;
    push_lsb(1'b1, 32'h0000_1234, c0 + 4);
    lsb_addr = 32'h200; lsb_len = 6'd16; lsb_ld_req = 1'b1;
    wait_lsb(); lsb_ld_req = 1'b0;

    // rdy low for two cycles mid-load delays completion by two
    c0 = cyc;
    push_lsb(1'b1, 32'h0000_1234, c0 + 6);
    lsb_addr = 32'h200; lsb_len = 6'd16; lsb_ld_req = 1'b1;
    fork
      begin wait_lsb(); lsb_ld_req = 1'b0; end
      begin step(2); rdy = 1'b0; step(2); rdy = 1'b1; end
    join

    // IO store while the UART buffer is full
    c0 = cyc;
`ifdef MEM_IO_STALL_EN
    push_wr(32'h0003_0000, 8'h41, c0 + 4);
    push_lsb(1'b0, 32'h0, c0 + 5);
`else
    push_wr(32'h0003_0000, 8'h41, c0 + 1);
    push_lsb(1'b0, 32'h0, c0 + 2);
`endif
    lsb_addr = 32'h0003_0000; lsb_len = 6'd8; lsb_wdata = 32'h0000_0041;
    lsb_st_req = 1'b1; io_buffer_full = 1'b1;
    fork
      begin wait_lsb(); lsb_st_req = 1'b0; end
      begin step(4); io_buffer_full = 1'b0; end
    join

    // address wrap-around on a halfword store
    c0 = cyc;
    push_wr(32'hFFFF_FFFF, 8'h11, c0 + 1); push_wr(32'h0000_0000, 8'h22, c0 + 2);
    push_lsb(1'b0, 32'h0, c0 + 3);
    lsb_addr = 32'hFFFF_FFFF; lsb_len = 6'd16; lsb_wdata = 32'h0000_2211; lsb_st_req = 1'b1;
    wait_lsb(); lsb_st_req = 1'b0;

    step(6);
    chk("wr_queue_empty", wq.size(), 32'd0);
    chk("lsb_queue_empty", lq.size(), 32'd0);
    chk("if_queue_empty", iq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
